// File: rtl/load_return_unit_pkg.sv
// rtl/load_return_unit_pkg.sv - shared load-side encodings and helpers
// Op codes match the store-side s_l_op encoding so MEM can forward one field to both paths.
package load_return_unit_pkg;

   localparam int ADDR_W_DEFAULT = 32;

   localparam logic [1:0] LD_W = 2'b00;
   localparam logic [1:0] LD_H = 2'b01;
   localparam logic [1:0] LD_B = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } lru_state_e;

   // Op 2'b11 falls into the word rule, matching how the extender treats it.
   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
      case (op)
         LD_B:    is_misaligned = 1'b0;
         LD_H:    is_misaligned = addr_lo[0];
         default: is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_return_unit_if.sv
// rtl/load_return_unit_if.sv - MEM-stage load request, data-memory read and WB result bundle
// The slave modport is the load unit itself; master is whatever drives it.
interface load_return_unit_if #(
   parameter int ADDR_W = load_return_unit_pkg::ADDR_W_DEFAULT
);
   logic              flush;
   logic              ld_req;
   logic [1:0]        ld_op;
   logic              ld_sign;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_ready;
   logic              stall;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   logic              ld_valid;
   logic [31:0]       ld_data;
   logic              ld_err;

   modport master (
      output flush, ld_req, ld_op, ld_sign, ld_addr, mem_ack, mem_rdata,
      input  ld_ready, stall, mem_req, mem_addr, ld_valid, ld_data, ld_err
   );

   modport slave (
      input  flush, ld_req, ld_op, ld_sign, ld_addr, mem_ack, mem_rdata,
      output ld_ready, stall, mem_req, mem_addr, ld_valid, ld_data, ld_err
   );

endinterface

// File: rtl/load_return_unit_load_extend.sv
// rtl/load_return_unit_load_extend.sv - little-endian lane select and sign/zero extension
// Purely combinational so the bypass network can reuse it on forwarded words.
module load_extend
   import load_return_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  op_i,
   input  logic        sign_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
      half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (op_i)
         LD_B:    result_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
         LD_H:    result_o = {{16{sign_i & half_lane[15]}}, half_lane};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_return_unit.sv
// rtl/load_return_unit.sv - MEM-stage load issue, variable-latency read and WB result return
// One load in flight at a time; the pipeline stalls from accept until the result cycle ends.
module load_return_unit
   import load_return_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = ADDR_W_DEFAULT
) (
   input logic               clk_i,
   input logic               reset_ni,
   load_return_unit_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lru_state_e        state_q;
   logic [1:0]        addr_lo_q;
   logic [1:0]        op_q;
   logic              sign_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              drop_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              ld_valid_q;
   logic [31:0]       ld_data_q;
   logic              ld_err_q;

   logic [31:0]       ext_data_d;
   logic              misaligned_d;
   logic              timeout_d;
   logic              drop_d;

   load_extend u_extend (
      .rdata_i  (bus.mem_rdata),
      .addr_i   (addr_lo_q),
      .op_i     (op_q),
      .sign_i   (sign_q),
      .result_o (ext_data_d)
   );

   always_comb begin
      misaligned_d = is_misaligned(bus.ld_op, bus.ld_addr[1:0]);
      timeout_d    = (cnt_q == CNT_LAST);
      drop_d       = drop_q | bus.flush;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         addr_lo_q  <= '0;
         op_q       <= LD_W;
         sign_q     <= 1'b0;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         ld_valid_q <= 1'b0;
         ld_data_q  <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         ld_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.ld_req && !bus.flush) begin
                  addr_lo_q <= bus.ld_addr[1:0];
                  op_q      <= bus.ld_op;
                  sign_q    <= bus.ld_sign;
                  cnt_q     <= '0;
                  drop_q    <= 1'b0;
                  if (misaligned_d) begin
                     state_q    <= ST_RESP;
                     ld_valid_q <= 1'b1;
                     ld_data_q  <= '0;
                     ld_err_q   <= 1'b1;
                  end else begin
                     state_q    <= ST_WAIT;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {bus.ld_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            // A flush here only marks the result for discard; the memory
            // handshake must still close so the slave is not left mid-transfer.
            ST_WAIT: begin
               drop_q <= drop_d;
               if (bus.mem_ack) begin
                  state_q    <= ST_RESP;
                  mem_req_q  <= 1'b0;
                  ld_valid_q <= !drop_d;
                  ld_data_q  <= ext_data_d;
                  ld_err_q   <= 1'b0;
               end else if (timeout_d) begin
                  state_q    <= ST_RESP;
                  mem_req_q  <= 1'b0;
                  ld_valid_q <= !drop_d;
                  ld_data_q  <= '0;
                  ld_err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               drop_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ld_ready = (state_q == ST_IDLE);
   assign bus.stall    = (state_q != ST_IDLE);
   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   // A flush arriving in the result cycle itself still has to squash the strobe.
   assign bus.ld_valid = ld_valid_q & ~bus.flush;
   assign bus.ld_data  = ld_data_q;
   assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_load_return_unit.sv
// tb/tb_load_return_unit.sv - directed vector table plus flush/reset sequences for load_return_unit
module tb_load_return_unit;
   import load_return_unit_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   load_return_unit_if #(.ADDR_W(32)) bus ();

   load_return_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus      (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          ack_at;
      int          flush_at;
      logic [31:0] exp_maddr;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_vcnt;
      int          exp_lat;
      int          exp_req;
      int          exp_stall;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat, vcnt, reqc, stallc;
      logic [31:0] data;
      logic err, addr_ok, done;
      lat = 0; vcnt = 0; reqc = 0; stallc = 0;
      data = '0; err = 1'b0; addr_ok = 1'b1; done = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d ready_before", idx), {31'b0, bus.ld_ready}, 32'd1);
      bus.ld_req  = 1'b1;
      bus.ld_op   = v.op;
      bus.ld_sign = v.sign;
      bus.ld_addr = v.addr;
      @(posedge clk);
      #1 bus.ld_req = 1'b0;
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         @(negedge clk);
         if (bus.stall) stallc++;
         if (bus.ld_valid) begin
            vcnt++;
            lat  = cyc;
            data = bus.ld_data;
            err  = bus.ld_err;
         end
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 32'hA5A5_A5A5;
         bus.flush     = 1'b0;
         if (bus.mem_req) begin
            reqc++;
            if (bus.mem_addr !== v.exp_maddr) addr_ok = 1'b0;
            if (reqc == v.ack_at) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = v.rdata;
            end
            if (reqc == v.flush_at) bus.flush = 1'b1;
         end
         if (bus.ld_ready) done = 1'b1;
      end
      bus.mem_ack = 1'b0;
      bus.flush   = 1'b0;
      check($sformatf("v%0d back_to_idle", idx), {31'b0, done}, 32'd1);
      check($sformatf("v%0d valid_count", idx), vcnt, v.exp_vcnt);
      if (v.exp_vcnt > 0) begin
         check($sformatf("v%0d latency", idx), lat, v.exp_lat);
         check($sformatf("v%0d ld_data", idx), data, v.exp_data);
         check($sformatf("v%0d ld_err", idx), {31'b0, err}, {31'b0, v.exp_err});
      end
      check($sformatf("v%0d mem_req_cycles", idx), reqc, v.exp_req);
      check($sformatf("v%0d stall_cycles", idx), stallc, v.exp_stall);
      if (v.exp_req > 0)
         check($sformatf("v%0d mem_addr", idx), {31'b0, addr_ok}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //        op    sg  addr          rdata         ack flu exp_maddr     exp_data      err vc lat req stall
      vecs[0]  = '{LD_B, 1'b1, 32'h0000_1003, 32'h80AB_CDEF, 1, 0, 32'h0000_1000, 32'hFFFF_FF80, 1'b0, 1, 2, 1, 2};
      vecs[1]  = '{LD_H, 1'b0, 32'h0000_2002, 32'h9234_5678, 4, 0, 32'h0000_2000, 32'h0000_9234, 1'b0, 1, 5, 4, 5};
      vecs[2]  = '{LD_W, 1'b0, 32'h0000_3001, 32'h1111_1111, 0, 0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 1, 0, 1};
      vecs[3]  = '{LD_H, 1'b1, 32'h0000_3003, 32'h1111_1111, 0, 0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 1, 0, 1};
      vecs[4]  = '{LD_W, 1'b0, 32'h0000_4000, 32'h1111_1111, 0, 0, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 17, 16, 17};
      vecs[5]  = '{LD_B, 1'b0, 32'h0000_5000, 32'h0000_00FF, 3, 1, 32'h0000_5000, 32'h0000_0000, 1'b0, 0, 0, 3, 4};
      vecs[6]  = '{LD_W, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, 2, 0, 32'h0000_5004, 32'hDEAD_BEEF, 1'b0, 1, 3, 2, 3};
      vecs[7]  = '{LD_B, 1'b0, 32'h0000_6001, 32'h1234_F0AB, 1, 0, 32'h0000_6000, 32'h0000_00F0, 1'b0, 1, 2, 1, 2};
      vecs[8]  = '{LD_H, 1'b1, 32'h0000_6000, 32'h0000_8001, 1, 0, 32'h0000_6000, 32'hFFFF_8001, 1'b0, 1, 2, 1, 2};
      vecs[9]  = '{2'b11, 1'b1, 32'h0000_6008, 32'h1122_3344, 1, 0, 32'h0000_6008, 32'h1122_3344, 1'b0, 1, 2, 1, 2};
      vecs[10] = '{LD_B, 1'b1, 32'h0000_6002, 32'h007F_0000, 1, 0, 32'h0000_6000, 32'h0000_007F, 1'b0, 1, 2, 1, 2};

      bus.flush = 1'b0; bus.ld_req = 1'b0; bus.ld_op = LD_W; bus.ld_sign = 1'b0;
      bus.ld_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

      @(negedge clk);
      check("reset ld_ready", {31'b0, bus.ld_ready}, 32'd1);
      check("reset stall", {31'b0, bus.stall}, 32'd0);
      check("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
      check("reset mem_addr", bus.mem_addr, 32'd0);
      check("reset ld_valid", {31'b0, bus.ld_valid}, 32'd0);
      check("reset ld_data", bus.ld_data, 32'd0);
      check("reset ld_err", {31'b0, bus.ld_err}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Request and flush together: flush wins, nothing is accepted.
      @(negedge clk);
      bus.ld_req = 1'b1; bus.flush = 1'b1; bus.ld_op = LD_W; bus.ld_addr = 32'h0000_9000;
      @(posedge clk);
      #1 bus.ld_req = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      check("flush_idle ld_ready", {31'b0, bus.ld_ready}, 32'd1);
      check("flush_idle mem_req", {31'b0, bus.mem_req}, 32'd0);
      check("flush_idle stall", {31'b0, bus.stall}, 32'd0);

      // Flush raised during the result cycle squashes the strobe.
      bus.ld_req = 1'b1; bus.ld_op = LD_W; bus.ld_addr = 32'h0000_7000;
      @(posedge clk);
      #1 bus.ld_req = 1'b0;
      @(negedge clk);
      check("flush_resp mem_req", {31'b0, bus.mem_req}, 32'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 bus.mem_ack = 1'b0; bus.flush = 1'b1;
      @(negedge clk);
      check("flush_resp ld_valid", {31'b0, bus.ld_valid}, 32'd0);
      check("flush_resp stall", {31'b0, bus.stall}, 32'd1);
      check("flush_resp ld_data", bus.ld_data, 32'hCAFE_F00D);
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("flush_resp ready_after", {31'b0, bus.ld_ready}, 32'd1);

      // Reset in WAIT drops mem_req with no clock edge; a late ack is ignored.
      bus.ld_req = 1'b1; bus.ld_op = LD_W; bus.ld_addr = 32'h0000_8000;
      @(posedge clk);
      #1 bus.ld_req = 1'b0;
      @(negedge clk);
      check("rst_mid mem_req_before", {31'b0, bus.mem_req}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid mem_req_async", {31'b0, bus.mem_req}, 32'd0);
      check("rst_mid ld_valid_async", {31'b0, bus.ld_valid}, 32'd0);
      check("rst_mid stall_async", {31'b0, bus.stall}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("rst_mid late_ack ld_valid", {31'b0, bus.ld_valid}, 32'd0);
      check("rst_mid late_ack mem_req", {31'b0, bus.mem_req}, 32'd0);
      check("rst_mid ld_ready", {31'b0, bus.ld_ready}, 32'd1);
      @(negedge clk);
      check("rst_mid ld_valid_later", {31'b0, bus.ld_valid}, 32'd0);

      run_vec(99, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_return_unit.md
Name: load_return_unit

Overview:
- Read-side counterpart to the MEM-stage store path.
- Accepts a load request from the MEM stage and issues a word-aligned read over a req/ack handshake to a variable-latency data memory.
- Extracts the addressed byte or halfword lane and sign- or zero-extends it.
- Returns a single-cycle result toward WB, and stalls the pipeline while the load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_req may stay high without mem_ack before the load is errored.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- flush  in  1  pipeline flush; kills the current or incoming load.
- ld_req  in  1  load request from MEM stage.
- ld_op  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- ld_sign  in  1  1 = sign-extend, 0 = zero-extend; ignored for word loads.
- ld_addr  in  ADDR_W  byte address (ALU result).
- ld_ready  out  1  unit can accept ld_req this cycle.
- stall  out  1  hold upstream pipeline.
- mem_req  out  1  read request to data memory.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- mem_ack  in  1  memory read data valid.
- mem_rdata  in  32  memory word.
- ld_valid  out  1  one-cycle result strobe.
- ld_data  out  32  extended load result.
- ld_err  out  1  misaligned or timeout; qualified by ld_valid.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: state IDLE, mem_req 0, mem_addr 0, ld_valid 0, ld_data 0, ld_err 0, timeout counter 0, drop flag 0. ld_ready=1 and stall=0.
- ld_ready = (state==IDLE). stall = (state!=IDLE).
- IDLE, accept condition: ld_req & ~flush. On accept, latch addr, op and sign.
- IDLE, alignment check on accept:
  - Misaligned means word with addr[1:0]!=0, or half with addr[0]!=0.
  - Misaligned -> RESP with err=1, data=0, and no mem_req issued.
  - Aligned -> WAIT; mem_req=1 and mem_addr valid from the next cycle; counter cleared.
- IDLE, ld_req & flush in the same cycle: flush wins; nothing is accepted.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack is sampled high.
  - On mem_ack: mem_req drops the next cycle, mem_rdata is captured and extracted, state -> RESP with err=0.
  - Counter increments each cycle without ack. If the counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req drops, state -> RESP with err=1, data=0.
  - mem_ack in the same cycle as the timeout: ack wins.
- Flush in WAIT:
  - Sets the drop flag.
  - The handshake still completes on ack or timeout; mem_req is never withdrawn early except on timeout.
- RESP:
  - ld_valid=1 for exactly one cycle, unless the drop flag is set or flush is high that cycle.
  - ld_data and ld_err are driven; state -> IDLE; drop flag clears.
  - ld_data holds its value afterwards. ld_valid=0 outside RESP.
- Extraction, little-endian:
  - Byte lane n = mem_rdata[8n+7:8n], with n = addr[1:0].
  - Half lane = addr[1] ? [31:16] : [15:0].
  - Word is passed through unchanged.
  - Extension: sign-extend if ld_sign, else zero-fill.
- mem_ack outside WAIT is ignored.
- Latency:
  - Accept at cycle T; mem_req high from T+1.
  - Ack sampled at cycle A gives ld_valid at A+1. Minimum accept-to-result is 2 cycles when ack arrives at T+1.
  - Misaligned load gives ld_valid at T+1.
- Back-to-back loads: a new request is accepted in the IDLE cycle following RESP, so there is at most one outstanding load.
- Reset asserted mid-operation: immediate return to the reset state; mem_req drops asynchronously and any pending result is discarded.

Decomposition:
- Shared package holds:
  - LD_W=2'b00, LD_H=2'b01, LD_B=2'b10 (same encoding as the store-side s_l_op).
  - State encoding IDLE/WAIT/RESP.
  - ADDR_W default.
- One combinational sub-module, load_extend: inputs rdata, addr[1:0], op, sign; output 32-bit result. It is reusable by the bypass logic.

Test Plan:
1. lb, sign=1, addr 0x0000_1003, ack after 1 cycle, rdata 0x80AB_CDEF -> mem_addr 0x0000_1000; ld_valid at T+2; ld_data 0xFFFF_FF80; ld_err 0; stall high 2 cycles.
2. lhu, sign=0, addr 0x0000_2002, ack after 4 cycles, rdata 0x9234_5678 -> ld_data 0x0000_9234; mem_req high exactly 4 cycles; ld_valid single pulse.
3. lw at addr 0x0000_3001 -> no mem_req; ld_valid at T+1 with ld_err=1 and ld_data 0. lh at 0x0000_3003 -> same error response.
4. lw at 0x0000_4000, mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles; ld_valid with ld_err=1; return to IDLE; the next ld_req is accepted.
5. lb at 0x0000_5000, flush pulsed in WAIT, ack after 3 cycles -> handshake completes; ld_valid never asserted; a following lw returns correct data.
6. reset driven low while in WAIT with mem_req=1 -> mem_req and ld_valid go 0 without waiting for a clock edge; ld_ready=1 after release; a late mem_ack is ignored.
